// File: rtl/pea_launch_sched.sv
// Round-robin launch scheduler for the PEA execution FSM: grants one requester,
// issues a start pulse per iteration and reports done or watchdog/abort error.
module pea_launch_sched #(
    parameter int N_REQ  = 4,
    parameter int ITER_W = 16,
    parameter int TO_W   = 20,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*ITER_W-1:0] req_iter_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [TO_W-1:0]         timeout_i,
    input  logic                    abort_i,
    output logic                    pea_start_o,
    input  logic                    pea_done_i,
    output logic [N_REQ-1:0]        done_o,
    output logic [N_REQ-1:0]        err_o,
    output logic                    busy_o,
    output logic [ID_W-1:0]         grant_id_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_COMPLETE,
        S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic [ITER_W-1:0] iter_left_reg, iter_left_next;
    logic [TO_W-1:0]   wdog_reg, wdog_next;
    logic              abort_pend_reg, abort_pend_next;

    logic [ID_W-1:0]   win_id;
    logic              any_valid;
    logic [ITER_W-1:0] iter_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_iter_slice
            assign iter_arr[gi] = req_iter_i[gi*ITER_W +: ITER_W];
        end
    endgenerate

    // Scan from the highest rotated offset down so the entry nearest the pointer wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_id    = '0;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_valid_i[idx]) begin
                win_id    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        grant_id_next   = grant_id_reg;
        iter_left_next  = iter_left_reg;
        wdog_next       = wdog_reg;
        abort_pend_next = abort_pend_reg;
        req_ready_o     = '0;
        pea_start_o     = 1'b0;
        done_o          = '0;
        err_o           = '0;

        case (state_reg)
            S_IDLE: begin
                abort_pend_next = 1'b0;
                if (any_valid) begin
                    req_ready_o    = N_REQ'(1) << win_id;
                    grant_id_next  = win_id;
                    iter_left_next = (iter_arr[win_id] == '0) ? ITER_W'(1) : iter_arr[win_id];
                    rr_ptr_next    = (int'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
                    state_next     = S_START;
                end
            end
            S_START: begin
                pea_start_o     = 1'b1;
                wdog_next       = timeout_i;
                // An abort seen while starting is held and acted on in the first WAIT cycle.
                abort_pend_next = abort_i;
                state_next      = S_WAIT;
            end
            S_WAIT: begin
                abort_pend_next = 1'b0;
                if (abort_i || abort_pend_reg) begin
                    state_next = S_ERROR;
                end else if (pea_done_i) begin
                    if (iter_left_reg <= ITER_W'(1)) begin
                        state_next = S_COMPLETE;
                    end else begin
                        iter_left_next = iter_left_reg - ITER_W'(1);
                        state_next     = S_START;
                    end
                end else if (wdog_reg == TO_W'(1)) begin
                    state_next = S_ERROR;
                end else if (wdog_reg != '0) begin
                    wdog_next = wdog_reg - TO_W'(1);
                end
            end
            S_COMPLETE: begin
                done_o     = N_REQ'(1) << grant_id_reg;
                state_next = S_IDLE;
            end
            S_ERROR: begin
                err_o      = N_REQ'(1) << grant_id_reg;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= S_IDLE;
            rr_ptr_reg     <= '0;
            grant_id_reg   <= '0;
            iter_left_reg  <= '0;
            wdog_reg       <= '0;
            abort_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            grant_id_reg   <= grant_id_next;
            iter_left_reg  <= iter_left_next;
            wdog_reg       <= wdog_next;
            abort_pend_reg <= abort_pend_next;
        end
    end

    assign busy_o     = (state_reg != S_IDLE);
    assign grant_id_o = busy_o ? grant_id_reg : '0;

endmodule

// File: tb/tb_pea_launch_sched.sv
// Bench for pea_launch_sched: directed scenarios plus random launches checked
// against a per-launch outcome model (earliest of abort/done/watchdog wins).
module tb_pea_launch_sched;

    localparam int BIG = 1000000;

    logic        clk_i;
    logic        rst_n_i;
    logic [3:0]  req_valid_i;
    logic [63:0] req_iter_i;
    logic [3:0]  req_ready_o;
    logic [19:0] timeout_i;
    logic        abort_i;
    logic        pea_start_o;
    logic        pea_done_i;
    logic [3:0]  done_o;
    logic [3:0]  err_o;
    logic        busy_o;
    logic [1:0]  grant_id_o;

    int checks = 0;
    int errors = 0;
    int rr_ptr = 0;

    pea_launch_sched dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_iter_i  (req_iter_i),
        .req_ready_o (req_ready_o),
        .timeout_i   (timeout_i),
        .abort_i     (abort_i),
        .pea_start_o (pea_start_o),
        .pea_done_i  (pea_done_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .grant_id_o  (grant_id_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [3:0] vmask);
        for (int i = 0; i < 4; i++) begin
            if (vmask[(rr_ptr + i) % 4]) return (rr_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [63:0] mk_iters(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // One launch: the PEA answers dly cycles after each start; abort rides with
    // done on iteration abort_it; a watchdog of tmo cycles preempts a later done.
    task automatic launch(input logic [3:0] vmask, input logic [63:0] iters, input int tmo,
                          input int dly, input int abort_it, output int got);
        int w, n, done_at, abort_at, wd_at, end_c, starts;
        bit is_err, fin;
        w = model_winner(vmask);
        n = int'(iters[w*16 +: 16]);
        if (n == 0) n = 1;
        got = -1;
        starts = 0;
        @(negedge clk_i);
        req_valid_i = vmask; req_iter_i = iters; timeout_i = 20'(tmo);
        pea_done_i = 1'b0; abort_i = 1'b0;
        #1;
        check("accept_ready", req_ready_o, 64'(1) << w);
        check("accept_idle", busy_o, 0);
        rr_ptr = (w + 1) % 4;
        @(negedge clk_i);
        #1;
        fin = 0;
        for (int it = 1; it <= n && !fin; it++) begin
            check("start_pulse", pea_start_o, 1);
            check("start_busy", busy_o, 1);
            check("start_grant", grant_id_o, w);
            check("start_ready", req_ready_o, 0);
            starts++;
            if (it == 1) got = int'(grant_id_o);
            done_at  = dly;
            abort_at = (it == abort_it) ? dly : BIG;
            wd_at    = (tmo > 0) ? tmo : BIG;
            is_err   = (abort_at < BIG) || (wd_at < done_at);
            end_c    = (done_at < wd_at) ? done_at : wd_at;
            for (int c = 1; c <= end_c; c++) begin
                @(negedge clk_i);
                pea_done_i = (c == done_at);
                abort_i    = (c == abort_at);
                #1;
                check("wait_quiet", {pea_start_o, done_o, err_o, busy_o}, 10'h001);
            end
            @(negedge clk_i);
            pea_done_i = 1'b0; abort_i = 1'b0;
            #1;
            if (is_err) begin
                check("err_pulse", {err_o, done_o, 3'b0, pea_start_o}, {4'(64'(1) << w), 8'h00});
                fin = 1;
                @(negedge clk_i);
                req_valid_i = 4'b0; pea_done_i = 1'b1;
                #1;
                check("late_done_idle", {busy_o, pea_start_o, req_ready_o}, 0);
                @(negedge clk_i);
                pea_done_i = 1'b0;
                #1;
                check("late_done_quiet", {busy_o, pea_start_o, done_o, err_o}, 0);
            end else if (it == n) begin
                check("done_pulse", {done_o, err_o, 3'b0, pea_start_o}, {4'(64'(1) << w), 8'h00});
                fin = 1;
            end
        end
        check("start_count_bound", (starts <= n), 1);
    endtask

    initial begin
        int got, vm, tmo, dly, ab;
        logic [63:0] its;
        rst_n_i = 1'b0; req_valid_i = 4'b0; req_iter_i = '0; timeout_i = '0;
        abort_i = 1'b0; pea_done_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_outputs", {pea_start_o, done_o, err_o, busy_o, grant_id_o, req_ready_o}, 0);
        req_valid_i = 4'b0100;
        #1;
        check("reset_ready_comb", req_ready_o, 4'b0100);
        req_valid_i = 4'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Single launch, requester 2, three iterations, no watchdog.
        launch(4'b0100, mk_iters(0, 0, 3, 0), 0, 5, 0, got);
        check("single_grant", got, 2);
        // Iteration count 0 behaves as 1.
        launch(4'b0010, mk_iters(0, 0, 0, 0), 0, 3, 0, got);
        check("iter0_grant", got, 1);
        // Watchdog expiry with no done, then done arriving on the expiry cycle.
        launch(4'b1000, mk_iters(0, 0, 0, 2), 8, BIG, 0, got);
        launch(4'b0001, mk_iters(1, 0, 0, 0), 8, 8, 0, got);
        // Abort together with done on iteration 2 of 4.
        launch(4'b0100, mk_iters(0, 0, 4, 0), 0, 3, 2, got);

        // Reset in WAIT after granting requester 1 (pointer would then be 2).
        @(negedge clk_i);
        req_valid_i = 4'b0010; req_iter_i = mk_iters(0, 2, 0, 0); timeout_i = '0;
        #1;
        check("rst_accept_ready", req_ready_o, 4'b0010);
        @(negedge clk_i);
        req_valid_i = 4'b0;
        #1;
        check("rst_start", pea_start_o, 1);
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_in_wait", {busy_o, pea_start_o}, 2'b10);
        rst_n_i = 1'b0;
        #1;
        check("rst_async_outputs", {pea_start_o, done_o, err_o, busy_o, grant_id_o, req_ready_o}, 0);
        rr_ptr = 0;
        @(negedge clk_i);
        #1;
        check("rst_held_quiet", {pea_start_o, done_o, err_o, busy_o}, 0);
        rst_n_i = 1'b1;

        // Fairness from reset: all requesters continuously valid.
        for (int i = 0; i < 5; i++) begin
            launch(4'hF, mk_iters(1, 1, 1, 1), 0, 2, 0, got);
            check("rr_order", got, i % 4);
        end

        for (int r = 0; r < 25; r++) begin
            vm  = $urandom_range(1, 15);
            its = mk_iters($urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3));
            tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 10);
            dly = $urandom_range(1, 12);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            launch(4'(vm), its, tmo, dly, ab, got);
        end

        @(negedge clk_i);
        req_valid_i = 4'b0;
        #1;
        check("final_idle", {busy_o, pea_start_o, done_o, err_o, req_ready_o}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pea_launch_sched.md
# pea_launch_sched

Launch scheduler in front of the PEA execution FSM. It arbitrates kernel-launch requests from `N_REQ` requesters (host cores, DMA-driven contexts) round-robin. For the granted requester it issues start pulses to the PEA for a programmed number of back-to-back iterations, using the PEA's done interrupt as the per-iteration completion. It reports completion, or a watchdog/abort error, to the owning requester.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, ≥ 2.
- `ITER_W`, default 16: width of the per-request iteration count.
- `TO_W`, default 20: width of the watchdog timeout.
- `ID_W`, default `$clog2(N_REQ)`: width of the grant index.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `N_REQ`: per-requester launch request. Held until accepted.
- `req_iter_i` in `N_REQ*ITER_W`: iteration count of requester k, in slice `[k*ITER_W +: ITER_W]`.
- `req_ready_o` out `N_REQ`: one-hot accept. A request is accepted when valid and ready are both high.
- `timeout_i` in `TO_W`: watchdog limit in cycles per iteration. 0 disables the watchdog.
- `abort_i` in 1: synchronous abort of the current launch.
- `pea_start_o` out 1: one-cycle start pulse to the PEA FSM.
- `pea_done_i` in 1: one-cycle PEA done interrupt.
- `done_o` out `N_REQ`: one-hot, one-cycle completion pulse to the owning requester.
- `err_o` out `N_REQ`: one-hot, one-cycle error pulse (watchdog expiry or abort).
- `busy_o` out 1: high whenever the state is not IDLE.
- `grant_id_o` out `ID_W`: index of the owning requester. Valid while `busy_o` is high; 0 when idle.

## Operation
- States: IDLE, START, WAIT, COMPLETE, ERROR.
- IDLE:
  - `req_ready_o` is combinational. It is one-hot on the round-robin winner whenever any `req_valid_i` is high, and 0 otherwise.
  - On accept, the block latches the winner index into `grant_id`.
  - It latches `iter_left` from the winner's count slice. A count of 0 is treated as 1.
  - It moves the RR pointer to winner+1, modulo `N_REQ`, then goes to START.
- Round-robin:
  - Search order is pointer, pointer+1, … with wrap-around.
  - The pointer resets to 0, so requester 0 has highest priority after reset.
  - The pointer advances only on accept.
- START:
  - `pea_start_o` = 1 for exactly this cycle.
  - The watchdog counter is loaded with `timeout_i`.
  - Next state is WAIT.
- WAIT, evaluated in this priority order:
  1. `abort_i` → ERROR.
  2. `pea_done_i` with `iter_left` == 1 → COMPLETE.
  3. `pea_done_i` with `iter_left` > 1 → decrement `iter_left`, go to START.
  4. Watchdog enabled and counter == 1 → ERROR. Otherwise the counter decrements every WAIT cycle.
- Abort in START: `pea_start_o` still fires in that cycle. The abort is registered and takes effect on the next cycle in WAIT.
- COMPLETE: `done_o[grant_id]` = 1 for one cycle, then IDLE.
- ERROR: `err_o[grant_id]` = 1 for one cycle, then IDLE. The PEA is not reset; the host is responsible for fabric recovery.
- `pea_done_i` outside WAIT is ignored. This covers spurious pulses and late done after an error.
- `req_valid_i` from other requesters is ignored while busy; their requests stay pending and are not dropped.
- Width rules:
  - `iter_left` is `ITER_W` bits, unsigned, and never decrements below 1.
  - The watchdog is `TO_W` bits and never wraps.

## Timing
- Reset values:
  - state = IDLE; RR pointer = 0; `grant_id` = 0; `iter_left` = 0; watchdog = 0.
  - Every output = 0, except `req_ready_o`, which follows the combinational IDLE rule, so it is 0 with no valid input.
- Accept at cycle t:
  - `pea_start_o` at t+1; state is WAIT from t+2.
  - `busy_o` = 1 from t+1.
- Done for the final iteration at cycle d:
  - `done_o` at d+1.
  - IDLE at d+2, where the next request can be accepted. Minimum gap between launches is 3 cycles.
- Done for an intermediate iteration at d: the next `pea_start_o` is at d+1. The PEA FSM is back in IDLE by then, so the start is captured.
- Watchdog with `timeout_i` = T > 0 and no done: the block spends T cycles in WAIT, then `err_o` pulses on the next cycle.
- `pea_done_i` in the same cycle the watchdog expires: done wins.
- `abort_i` in the same cycle as `pea_done_i`: abort wins, and `err_o` is reported instead of `done_o`.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous). No `done_o` or `err_o` pulse is emitted.

## Test plan
- Single launch: requester 2 with `req_iter` = 3 and `timeout_i` = 0. PEA model asserts done 5 cycles after each start. Required: exactly 3 `pea_start_o` pulses, then `done_o` = 4'b0100 at done+1, and `busy_o` low at done+2.
- Round-robin fairness: all 4 requesters continuously valid, each with iter = 1, starting from reset. Required: grant order 0, 1, 2, 3, 0, with exactly one `req_ready_o` bit per accept.
- Iteration count 0: requester 1 with iter = 0. Required: exactly 1 start and 1 `done_o[1]`.
- Watchdog expiry: `timeout_i` = 8 and the PEA never asserts done. Required: `err_o[grant]` 9 cycles after the START cycle. A late `pea_done_i` afterwards produces no output. Repeat with done on the expiry cycle: required `done_o`, no `err_o`.
- Abort: `abort_i` asserted together with `pea_done_i` on iteration 2 of 4. Required: `err_o` the following cycle, no further starts, and no `done_o`.
- Reset mid-WAIT: `rst_n_i` pulled low while in WAIT. Required: all outputs 0 immediately. After release, the RR pointer is back to 0 and requester 0 wins.
